// File: rtl/shift_seq_if.sv
// shift_seq_if: request/result handshake bundle for the iterative shift sequencer.
//   start_valid/start_ready   request handshake (op, shamt, data_in sampled at accept)
//   op                        00 SLL, 01 SRL, 10 SRA, 11 ROR
//   shamt                     5-bit shift amount
//   data_in                   operand
//   res_valid/res_ready       result handshake
//   result                    shifted value, meaningful while res_valid=1
//   stage_sel                 one-hot stage applied this cycle (bit k = shift by 2^k)
// Modports: master = requester/consumer side, slave = sequencer side.
interface shift_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [1:0]       op;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] data_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic [4:0]       stage_sel;

    modport master (
        output start_valid, op, shamt, data_in, res_ready,
        input  start_ready, res_valid, result, stage_sel
    );

    modport slave (
        input  start_valid, op, shamt, data_in, res_ready,
        output start_ready, res_valid, result, stage_sel
    );
endinterface

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle 32-bit shifter applying one binary stage (16/8/4/2/1) per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_seq_if.slave (request handshake, result handshake, stage_sel)
// Configuration macro SHIFT_SEQ_SKIP_EN:
//   defined   - only stages whose shamt bit is set are visited (latency = popcount(shamt))
//   undefined - all five stages are visited, fixed 5-cycle latency
module shift_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    shift_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [4:0]       sel;

`ifdef SHIFT_SEQ_SKIP_EN
    // Stage bits still to be applied; cleared MSB first.
    logic [4:0]       rem_q, rem_d;
`else
    logic [4:0]       shamt_q, shamt_d;
    logic [2:0]       k_q, k_d;
`endif

    // The one-hot stage select doubles as the shift amount (2^k).
    function automatic logic [WIDTH-1:0] apply_stage(input logic [1:0]       op,
                                                     input logic [WIDTH-1:0] w,
                                                     input logic [4:0]       s_oh);
        int unsigned s;
        logic [WIDTH-1:0] r;
        s = {27'd0, s_oh};
        unique case (op)
            2'b00:   r = w << s;
            2'b01:   r = w >> s;
            2'b10:   r = $signed(w) >>> s;
            default: r = (w >> s) | (w << (WIDTH - s));
        endcase
        return r;
    endfunction

`ifdef SHIFT_SEQ_SKIP_EN
    function automatic logic [4:0] msb_onehot(input logic [4:0] m);
        logic [4:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (m[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        sel     = '0;
`ifdef SHIFT_SEQ_SKIP_EN
        rem_d   = rem_q;
`else
        shamt_d = shamt_q;
        k_d     = k_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start_valid) begin
                    op_d   = bus.op;
                    work_d = bus.data_in;
`ifdef SHIFT_SEQ_SKIP_EN
                    rem_d   = bus.shamt;
                    state_d = (bus.shamt == 5'd0) ? StDone : StShift;
`else
                    shamt_d = bus.shamt;
                    k_d     = 3'd4;
                    state_d = StShift;
`endif
                end
            end
            StShift: begin
`ifdef SHIFT_SEQ_SKIP_EN
                sel    = msb_onehot(rem_q);
                work_d = apply_stage(op_q, work_q, sel);
                rem_d  = rem_q & ~sel;
                if (rem_d == 5'd0) state_d = StDone;
`else
                sel = 5'b00001 << k_q;
                // Unapplied stages still take a cycle to keep latency fixed.
                if ((sel & shamt_q) != 5'd0) work_d = apply_stage(op_q, work_q, sel);
                if (k_q == 3'd0) state_d = StDone;
                else             k_d     = k_q - 3'd1;
`endif
            end
            StDone: begin
                if (bus.res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 2'b00;
            work_q  <= '0;
`ifdef SHIFT_SEQ_SKIP_EN
            rem_q   <= '0;
`else
            shamt_q <= '0;
            k_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
`ifdef SHIFT_SEQ_SKIP_EN
            rem_q   <= rem_d;
`else
            shamt_q <= shamt_d;
            k_q     <= k_d;
`endif
        end
    end

    assign bus.start_ready = (state_q == StIdle);
    assign bus.res_valid   = (state_q == StDone);
    assign bus.result      = work_q;
    assign bus.stage_sel   = sel;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    shift_seq_if #(.WIDTH(32)) bus ();

    shift_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef SHIFT_SEQ_SKIP_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  sh;
        logic [31:0] d;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] sh,
                                              input logic [31:0] d);
        logic [31:0] r;
        case (op)
            2'b00: r = d << sh;
            2'b01: r = d >> sh;
            2'b10: r = $signed(d) >>> sh;
            default: r = (sh == 5'd0) ? d : ((d >> sh) | (d << (6'd32 - {1'b0, sh})));
        endcase
        return r;
    endfunction

    task automatic run_txn(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d,
                           input logic [31:0] exp, input int hold);
        logic [4:0]  seq[5];
        int          lat;
        int          waited;
        logic [31:0] got;
        logic [31:0] exp_r;
        @(negedge clk);
        bus.op = op;
        bus.shamt = sh;
        bus.data_in = d;
        bus.start_valid = 1'b1;
        bus.res_ready = 1'b0;
        check("start_ready_idle", {31'd0, bus.start_ready}, 32'd1);
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept; they must be ignored.
        bus.start_valid = 1'b0;
        bus.op = ~op;
        bus.shamt = ~sh;
        bus.data_in = ~d;
        lat = 0;
        for (int k = 4; k >= 0; k--) begin
            if (!Skip || sh[k]) begin
                seq[lat] = 5'd0;
                seq[lat][k] = 1'b1;
                lat++;
            end
        end
        for (int i = 0; i < lat; i++) begin
            check("stage_sel", {27'd0, bus.stage_sel}, {27'd0, seq[i]});
            check("res_valid_early", {31'd0, bus.res_valid}, 32'd0);
            @(negedge clk);
        end
        waited = 0;
        while (!bus.res_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("res_valid_latency_extra", waited, 0);
        check("stage_sel_done", {27'd0, bus.stage_sel}, 32'd0);
        check("start_ready_done", {31'd0, bus.start_ready}, 32'd0);
        got = bus.result;
        exp_r = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check("result", got, exp_r);
        // Backpressure: competing request must be ignored.
        bus.start_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
            check("bp_result", bus.result, exp_r);
            check("bp_start_ready", {31'd0, bus.start_ready}, 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start_valid = 1'b0;
        check("res_valid_cleared", {31'd0, bus.res_valid}, 32'd0);
        check("start_ready_back", {31'd0, bus.start_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        logic [1:0]  rop;
        logic [4:0]  rsh;
        logic [31:0] rd;

        vecs[0]  = '{2'b00, 5'd8,  32'h0000_00FF, 32'h0000_FF00, 0};
        vecs[1]  = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 0};
        vecs[2]  = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 0};
        vecs[3]  = '{2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000, 0};
        vecs[4]  = '{2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678, 0};
        vecs[5]  = '{2'b01, 5'd20, 32'h1234_5678, 32'h0000_0123, 1};
        vecs[6]  = '{2'b11, 5'd4,  32'h1234_5678, 32'h8123_4567, 0};
        vecs[7]  = '{2'b10, 5'd4,  32'h7000_0000, 32'h0700_0000, 0};
        vecs[8]  = '{2'b10, 5'd4,  32'hF000_0000, 32'hFF00_0000, 0};
        vecs[9]  = '{2'b11, 5'd16, 32'h8000_0001, 32'h0001_8000, 0};
        vecs[10] = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 0};
        vecs[11] = '{2'b00, 5'd3,  32'h0000_00A5, 32'h0000_0528, 3};

        bus.start_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.op = 2'b00;
        bus.shamt = 5'd0;
        bus.data_in = 32'd0;
        #1;
        check("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_stage_sel", {27'd0, bus.stage_sel}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_txn(vecs[i].op, vecs[i].sh, vecs[i].d, vecs[i].exp, vecs[i].hold);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            rsh = 5'($urandom_range(0, 31));
            rd = $urandom;
            run_txn(rop, rsh, rd, ref_shift(rop, rsh, rd), int'($urandom_range(0, 2)));
        end

        // Reset abort in the middle of SHIFT (after E2).
        @(negedge clk);
        bus.op = 2'b00;
        bus.shamt = 5'd31;
        bus.data_in = 32'hFFFF_FFFF;
        bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_stage_sel_pre", {27'd0, bus.stage_sel}, 32'h0000_0004);
        rst_n = 1'b0;
        #1;
        check("abort_start_ready", {31'd0, bus.start_ready}, 32'd1);
        check("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_stage_sel", {27'd0, bus.stage_sel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(2'b01, 5'd4, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
